// File: rtl/spi_slave_tx_16_pkg.sv
// Shared constants, state type and helpers for the oversampled SPI slave shift stage.
// Mode 0 only: MOSI sampled on SCK rising, MISO changed on SCK falling.
package spi_slave_tx_16_pkg;

   localparam int DATA_W      = 16;
   localparam int SYNC_STAGES = 2;
   localparam int IDX_W       = 2;
   localparam int CNT_W       = $clog2(DATA_W);
   localparam int CPOL        = 0;
   localparam int CPHA        = 0;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] v);
      return (&v) ? v : v + IDX_W'(1'b1);
   endfunction

endpackage

// File: rtl/spi_slave_tx_16_pin_sync.sv
// Multi-stage synchroniser for one asynchronous SPI pin, with rise/fall pulses
// derived from the last stage and one extra history register.
module spi_pin_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // synchroniser chain and edge history
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], pin_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  =  sync_q[STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_slave_tx_16.sv
// SPI mode-0 slave: shifts the upstream parallel word out on MISO and a command word in
// on MOSI, all in the clk domain; tx_ack tells the upstream mux a word was captured.
module spi_slave_tx_16
   import spi_slave_tx_16_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ack,
   input  logic              sck,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic [IDX_W-1:0]  word_idx,
   output logic              frame_err
);

   logic sck_lvl_unused_s, sck_rise_s, sck_fall_s;
   logic cs_lvl_unused_s, cs_rise_s, cs_fall_s;
   logic mosi_s, mosi_rise_unused_s, mosi_fall_unused_s;

   spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
      .clk_i(clk), .rst_i(rst), .pin_i(sck),
      .level_o(sck_lvl_unused_s), .rise_o(sck_rise_s), .fall_o(sck_fall_s));

   spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
      .clk_i(clk), .rst_i(rst), .pin_i(cs_n),
      .level_o(cs_lvl_unused_s), .rise_o(cs_rise_s), .fall_o(cs_fall_s));

   spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk_i(clk), .rst_i(rst), .pin_i(mosi),
      .level_o(mosi_s), .rise_o(mosi_rise_unused_s), .fall_o(mosi_fall_unused_s));

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [IDX_W-1:0]  word_idx_q, word_idx_d;
   logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              reload_pend_q, reload_pend_d;
   logic              miso_q, miso_d;
   logic              miso_oe_q, miso_oe_d;
   logic              tx_ack_q, tx_ack_d;
   logic              rx_valid_q, rx_valid_d;
   logic              frame_err_q, frame_err_d;

   // state and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         bit_cnt_q     <= '0;
         word_idx_q    <= '0;
         tx_shift_q    <= '0;
         rx_shift_q    <= '0;
         rx_data_q     <= '0;
         reload_pend_q <= 1'b0;
         miso_q        <= 1'b0;
         miso_oe_q     <= 1'b0;
         tx_ack_q      <= 1'b0;
         rx_valid_q    <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         word_idx_q    <= word_idx_d;
         tx_shift_q    <= tx_shift_d;
         rx_shift_q    <= rx_shift_d;
         rx_data_q     <= rx_data_d;
         reload_pend_q <= reload_pend_d;
         miso_q        <= miso_d;
         miso_oe_q     <= miso_oe_d;
         tx_ack_q      <= tx_ack_d;
         rx_valid_q    <= rx_valid_d;
         frame_err_q   <= frame_err_d;
      end
   end

   // next-state and output decode; cs_n edges take priority over sck edges
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      word_idx_d    = word_idx_q;
      tx_shift_d    = tx_shift_q;
      rx_shift_d    = rx_shift_q;
      rx_data_d     = rx_data_q;
      reload_pend_d = reload_pend_q;
      miso_d        = miso_q;
      miso_oe_d     = miso_oe_q;
      tx_ack_d      = 1'b0;
      rx_valid_d    = 1'b0;
      frame_err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall_s) begin
               state_d       = ACTIVE;
               tx_shift_d    = tx_data;
               miso_d        = tx_data[DATA_W-1];
               tx_ack_d      = 1'b1;
               bit_cnt_d     = '0;
               word_idx_d    = '0;
               rx_shift_d    = '0;
               reload_pend_d = 1'b0;
               miso_oe_d     = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         ACTIVE: begin
            if (cs_rise_s) begin
               state_d       = IDLE;
               miso_oe_d     = 1'b0;
               miso_d        = 1'b0;
               reload_pend_d = 1'b0;
               frame_err_d   = (bit_cnt_q != '0);
            end else if (sck_rise_s) begin
               rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
               if (bit_cnt_q == CNT_W'(DATA_W-1)) begin
                  rx_data_d     = {rx_shift_q[DATA_W-2:0], mosi_s};
                  rx_valid_d    = 1'b1;
                  bit_cnt_d     = '0;
                  reload_pend_d = 1'b1;
                  word_idx_d    = sat_inc(word_idx_q);
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1'b1);
               end
            end else if (sck_fall_s) begin
               if (reload_pend_q) begin
                  tx_shift_d    = tx_data;
                  miso_d        = tx_data[DATA_W-1];
                  tx_ack_d      = 1'b1;
                  reload_pend_d = 1'b0;
               end else begin
                  tx_shift_d = tx_shift_q << 1;
                  miso_d     = tx_shift_q[DATA_W-2];
               end
            end else begin
               state_d = ACTIVE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign tx_ack    = tx_ack_q;
   assign miso      = miso_q;
   assign miso_oe   = miso_oe_q;
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign word_idx  = word_idx_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_tx_16.sv
// Randomised bench for spi_slave_tx_16: frames are described as word lists and bit counts,
// and expected MISO/rx words, ack/valid/error counts and word_idx follow from plain arithmetic.
module tb_spi_slave_tx_16;
   import spi_slave_tx_16_pkg::*;

   logic        clk = 1'b0;
   logic        rst, sck, cs_n, mosi;
   logic [15:0] tx_data;
   logic        tx_ack, miso, miso_oe, rx_valid, frame_err;
   logic [15:0] rx_data;
   logic [1:0]  word_idx;

   always #10 clk = ~clk;

   spi_slave_tx_16 dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_ack(tx_ack),
      .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
      .rx_data(rx_data), .rx_valid(rx_valid), .word_idx(word_idx), .frame_err(frame_err));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [15:0] frame_tx[$];
   logic [15:0] frame_mo[$];
   logic [15:0] up_words[$];
   int          up_idx;
   int          ack_cnt, rxv_cnt, ferr_cnt;
   logic [15:0] rx_seen[$];
   logic [1:0]  idx_seen[$];
   logic [15:0] last_rx;

   // upstream mux model and output event monitor
   always @(negedge clk) begin
      if (tx_ack) begin
         ack_cnt <= ack_cnt + 1;
         up_idx  <= up_idx + 1;
         if (up_idx + 1 < up_words.size()) tx_data <= up_words[up_idx + 1];
         else tx_data <= 16'($urandom);
      end
      if (rx_valid) begin
         rxv_cnt <= rxv_cnt + 1;
         rx_seen.push_back(rx_data);
         idx_seen.push_back(word_idx);
      end
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      ack_cnt = 0; rxv_cnt = 0; ferr_cnt = 0;
      rx_seen.delete(); idx_seen.delete();
   endtask

   task automatic fill_random(input int nbits);
      int nw;
      nw = (nbits + 15) / 16;
      frame_tx.delete(); frame_mo.delete();
      for (int i = 0; i < nw + 1; i++) frame_tx.push_back(16'($urandom));
      for (int i = 0; i < nw + 1; i++) frame_mo.push_back(16'($urandom));
   endtask

   // one cs_n frame of nbits SCK cycles; the last falling SCK coincides with cs_n rising
   task automatic run_frame(input string nm, input int nbits, input int hp);
      logic [15:0] got[$];
      logic [15:0] acc;
      int exp_words, exp_acks, exp_idx;
      up_words = frame_tx; up_idx = 0; tx_data = frame_tx[0];
      cs_n = 1'b1; sck = 1'b0; wait_clk(6);
      clear_counts();
      cs_n = 1'b0; wait_clk(6);
      check_eq({nm, "_oe_on"}, miso_oe, 1);
      acc = 16'h0000;
      for (int b = 0; b < nbits; b++) begin
         mosi = frame_mo[b / 16][15 - (b % 16)];
         wait_clk(hp);
         acc = {acc[14:0], miso};
         if (b % 16 == 15) got.push_back(acc);
         sck = 1'b1;
         wait_clk(hp);
         sck = 1'b0;
         if (b == nbits - 1) cs_n = 1'b1;
      end
      if (nbits == 0) cs_n = 1'b1;
      wait_clk(SYNC_STAGES + 1);
      check_eq({nm, "_oe_off"}, miso_oe, 0);
      check_eq({nm, "_miso_off"}, miso, 0);
      wait_clk(5);
      exp_words = nbits / 16;
      exp_acks  = (nbits == 0) ? 1 : 1 + (nbits - 1) / 16;
      check_eq({nm, "_tx_acks"}, ack_cnt, exp_acks);
      check_eq({nm, "_rx_valids"}, rxv_cnt, exp_words);
      check_eq({nm, "_frame_err"}, ferr_cnt, (nbits % 16 != 0) ? 1 : 0);
      for (int k = 0; k < exp_words; k++) begin
         check_eq({nm, "_miso_word"}, got[k], frame_tx[k]);
         if (k < rx_seen.size()) begin
            exp_idx = (k + 1 > 3) ? 3 : k + 1;
            check_eq({nm, "_rx_word"}, rx_seen[k], frame_mo[k]);
            check_eq({nm, "_idx_at_word"}, idx_seen[k], exp_idx);
         end
      end
      if (exp_words > 0) last_rx = frame_mo[exp_words - 1];
      check_eq({nm, "_rx_data"}, rx_data, last_rx);
      check_eq({nm, "_word_idx_end"}, word_idx, (exp_words > 3) ? 3 : exp_words);
   endtask

   initial begin
      rst = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0; tx_data = 16'h0000;
      up_idx = 0; last_rx = 16'h0000;
      clear_counts();
      wait_clk(3);
      check_eq("rst_miso", miso, 0);
      check_eq("rst_oe", miso_oe, 0);
      check_eq("rst_rx_data", rx_data, 0);
      check_eq("rst_flags", {tx_ack, rx_valid, frame_err, word_idx}, 0);
      rst = 1'b0;
      wait_clk(4);

      // single word
      frame_tx.delete(); frame_mo.delete();
      frame_tx.push_back(16'h0064); frame_tx.push_back(16'h1111);
      frame_mo.push_back(16'hA5C3);
      run_frame("single", 16, 4);

      // three-word burst
      frame_tx.delete(); frame_mo.delete();
      frame_tx.push_back(16'h0064); frame_tx.push_back(16'hB1E0);
      frame_tx.push_back(16'h7530); frame_tx.push_back(16'h2222);
      for (int i = 0; i < 3; i++) frame_mo.push_back(16'($urandom));
      run_frame("burst", 48, 4);

      // aborted frame
      fill_random(9);
      run_frame("abort", 9, 4);

      // saturation of word_idx
      fill_random(80);
      run_frame("sat", 80, 4);

      // reset mid-frame with cs_n held low
      fill_random(16);
      up_words = frame_tx; up_idx = 0; tx_data = frame_tx[0];
      cs_n = 1'b0; wait_clk(6);
      for (int b = 0; b < 5; b++) begin
         mosi = frame_mo[0][15 - b];
         wait_clk(4); sck = 1'b1; wait_clk(4); sck = 1'b0;
      end
      wait_clk(1);
      rst = 1'b1;
      #1;
      last_rx = 16'h0000;
      check_eq("mid_rst_miso", miso, 0);
      check_eq("mid_rst_oe", miso_oe, 0);
      check_eq("mid_rst_rx_data", rx_data, 0);
      check_eq("mid_rst_flags", {tx_ack, rx_valid, frame_err, word_idx}, 0);
      wait_clk(2);
      rst = 1'b0;
      clear_counts();
      for (int b = 0; b < 8; b++) begin
         mosi = 1'($urandom); wait_clk(4); sck = 1'b1; wait_clk(4); sck = 1'b0;
      end
      wait_clk(4);
      check_eq("post_rst_acks", ack_cnt, 0);
      check_eq("post_rst_valids", rxv_cnt, 0);
      check_eq("post_rst_oe", miso_oe, 0);
      run_frame("after_rst", 16, 4);

      // idle noise on SCK with cs_n high
      cs_n = 1'b1; clear_counts();
      for (int b = 0; b < 20; b++) begin
         mosi = 1'($urandom); wait_clk(4); sck = 1'b1; wait_clk(4); sck = 1'b0;
      end
      wait_clk(4);
      check_eq("idle_acks", ack_cnt, 0);
      check_eq("idle_valids", rxv_cnt, 0);
      check_eq("idle_errs", ferr_cnt, 0);
      check_eq("idle_oe", miso_oe, 0);

      // random frames
      for (int f = 0; f < 8; f++) begin
         int nb, hp;
         nb = (f % 2 == 0) ? 16 * $urandom_range(1, 4) : $urandom_range(1, 70);
         hp = $urandom_range(4, 6);
         fill_random(nb);
         run_frame("rand", nb, hp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
